iomem_gpio_disp: RTL and testbench



---
 rtl/iomem_gpio_disp.sv | 174 +++++++++++++++++
 tb/tb_iomem_gpio_disp.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/iomem_gpio_disp.sv
// iomem GPIO/display peripheral: LED reg, debounced switches, 7-seg scanner, IRQ.
// Ports: clk/resetn, iomem_* bus slave, sw in, led/seg/an/irq out.
module iomem_gpio_disp #(
    parameter logic [7:0] BASE_HI  = 8'h03,
    parameter int         N_SW     = 16,
    parameter int         N_LED    = 16,
    parameter int         N_DIGITS = 4,
    parameter int         SCAN_DIV = 100000,
    parameter int         DEB_DIV  = 500000
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                iomem_valid,
    output logic                iomem_ready,
    input  logic [3:0]          iomem_wstrb,
    input  logic [31:0]         iomem_addr,
    input  logic [31:0]         iomem_wdata,
    output logic [31:0]         iomem_rdata,
    input  logic [N_SW-1:0]     sw,
    output logic [N_LED-1:0]    led,
    output logic [6:0]          seg,
    output logic [N_DIGITS-1:0] an,
    output logic                irq
);

    localparam int IW  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int SCW = $clog2(SCAN_DIV);
    localparam int DCW = $clog2(DEB_DIV);
    localparam int DW  = 4 * N_DIGITS;

    function automatic logic [6:0] hex7(input logic [3:0] h);
        case (h)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    logic [N_SW-1:0]  sw_s1, sw_s2, sw_smp, sw_deb, deb_n, agree;
    logic [DW-1:0]    disp_q;
    logic [1:0]       ctrl_q;
    logic             pend_q;
    logic [SCW-1:0]   scan_cnt;
    logic [DCW-1:0]   deb_cnt;
    logic [IW-1:0]    idx;

    logic             sel, wr, deb_tick, deb_chg, scan_wrap, w1c;
    logic [2:0]       off;
    logic [31:0]      wmask, rd_n, led_x, sw_x, disp_x;
    logic [3:0]       nib;
    logic [N_DIGITS-1:0] an_n;

    logic unused_bits;
    assign unused_bits = ^{iomem_addr[23:5], iomem_addr[1:0], iomem_wdata, wmask};

    always_comb begin
        sel   = iomem_valid && !iomem_ready && (iomem_addr[31:24] == BASE_HI);
        wr    = sel && (iomem_wstrb != 4'b0000);
        off   = iomem_addr[4:2];
        wmask = {{8{iomem_wstrb[3]}}, {8{iomem_wstrb[2]}},
                 {8{iomem_wstrb[1]}}, {8{iomem_wstrb[0]}}};
        w1c   = wr && (off == 3'd4) && iomem_wstrb[0] && iomem_wdata[0];

        led_x  = '0;
        led_x[N_LED-1:0] = led;
        sw_x   = '0;
        sw_x[N_SW-1:0] = sw_deb;
        disp_x = '0;
        disp_x[DW-1:0] = disp_q;

        case (off)
            3'd0:    rd_n = led_x;
            3'd1:    rd_n = sw_x;
            3'd2:    rd_n = disp_x;
            3'd3:    rd_n = {30'd0, ctrl_q};
            3'd4:    rd_n = {31'd0, pend_q};
            default: rd_n = '0;
        endcase
    end

    // A switch bit only moves once two consecutive ticks saw the same level.
    always_comb begin
        deb_tick = (deb_cnt == DCW'(DEB_DIV - 1));
        agree    = ~(sw_smp ^ sw_s2);
        deb_n    = deb_tick ? ((sw_deb & ~agree) | (sw_s2 & agree)) : sw_deb;
        deb_chg  = (deb_n != sw_deb);
    end

    always_comb begin
        scan_wrap = (scan_cnt == SCW'(SCAN_DIV - 1));
        nib  = '0;
        an_n = '1;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (idx == IW'(k)) begin
                nib     = disp_q[4*k +: 4];
                an_n[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            iomem_ready <= 1'b0;
            iomem_rdata <= '0;
            led         <= '0;
            disp_q      <= '0;
            ctrl_q      <= '0;
        end else begin
            iomem_ready <= sel;
            if (sel) iomem_rdata <= rd_n;
            if (wr) begin
                case (off)
                    3'd0: led <= (led & ~wmask[N_LED-1:0]) |
                                 (iomem_wdata[N_LED-1:0] & wmask[N_LED-1:0]);
                    3'd2: disp_q <= (disp_q & ~wmask[DW-1:0]) |
                                    (iomem_wdata[DW-1:0] & wmask[DW-1:0]);
                    3'd3: if (iomem_wstrb[0]) ctrl_q <= iomem_wdata[1:0];
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sw_s1   <= '0;
            sw_s2   <= '0;
            sw_smp  <= '0;
            sw_deb  <= '0;
            deb_cnt <= '0;
            pend_q  <= 1'b0;
            irq     <= 1'b0;
        end else begin
            sw_s1   <= sw;
            sw_s2   <= sw_s1;
            deb_cnt <= deb_tick ? '0 : deb_cnt + DCW'(1);
            if (deb_tick) sw_smp <= sw_s2;
            sw_deb  <= deb_n;
            // A fresh change wins over a simultaneous clear.
            if (deb_chg)  pend_q <= 1'b1;
            else if (w1c) pend_q <= 1'b0;
            irq     <= pend_q & ctrl_q[1];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            scan_cnt <= '0;
            idx      <= '0;
            an       <= '1;
            seg      <= 7'h7F;
        end else begin
            scan_cnt <= scan_wrap ? '0 : scan_cnt + SCW'(1);
            if (scan_wrap)
                idx <= (idx == IW'(N_DIGITS - 1)) ? '0 : idx + IW'(1);
            an  <= ctrl_q[0] ? an_n : '1;
            seg <= ctrl_q[0] ? ~hex7(nib) : 7'h7F;
        end
    end

endmodule

// File: tb/tb_iomem_gpio_disp.sv
// Bench for iomem_gpio_disp: vector table over the bus, scan/debounce/irq sequences.
// Bus reads are scoreboarded; expected data is queued when a request is issued.
module tb_iomem_gpio_disp;

    localparam int SCAN = 4;
    localparam int DEB  = 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        iomem_valid = 1'b0;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb = '0;
    logic [31:0] iomem_addr = '0;
    logic [31:0] iomem_wdata = '0;
    logic [31:0] iomem_rdata;
    logic [15:0] sw = '0;
    logic [15:0] led;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        irq;

    iomem_gpio_disp #(
        .BASE_HI(8'h03), .N_SW(16), .N_LED(16), .N_DIGITS(4),
        .SCAN_DIV(SCAN), .DEB_DIV(DEB)
    ) dut (
        .clk(clk), .resetn(resetn),
        .iomem_valid(iomem_valid), .iomem_ready(iomem_ready),
        .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr),
        .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata),
        .sw(sw), .led(led), .seg(seg), .an(an), .irq(irq)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int unsigned ecount;

    // Cycles since reset release; the debounce tick falls where ecount%DEB == DEB-1.
    always @(posedge clk or negedge resetn)
        if (!resetn) ecount <= 0;
        else         ecount <= ecount + 1;

    typedef struct {
        logic        chk;
        logic [31:0] exp;
        string       name;
    } sb_t;
    sb_t sbq[$];

    typedef struct {
        logic [2:0]  off;
        logic [3:0]  strb;
        logic [31:0] wd;
        logic        chk;
        logic [31:0] exp;
    } vec_t;
    vec_t vt[24];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Called at a negedge; returns one negedge after the acknowledge.
    task automatic bus(input logic [2:0] off, input logic [3:0] strb,
                       input logic [31:0] wd, input logic chk,
                       input logic [31:0] exp, input string nm);
        sb_t e;
        bit got = 0;
        e.chk = chk; e.exp = exp; e.name = nm;
        sbq.push_back(e);
        iomem_valid = 1'b1;
        iomem_addr  = {8'h03, 19'd0, off, 2'b00};
        iomem_wstrb = strb;
        iomem_wdata = wd;
        for (int i = 0; i < 6 && !got; i++) begin
            @(negedge clk);
            if (iomem_ready) got = 1;
        end
        iomem_valid = 1'b0;
        iomem_wstrb = '0;
        e = sbq.pop_front();
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s_ready: got 0 expected 1", nm);
        end else if (e.chk) begin
            check(e.name, iomem_rdata, e.exp);
        end
        @(negedge clk);
        check({nm, "_rdy1"}, {31'd0, iomem_ready}, 32'd0);
    endtask

    task automatic wait_tick_edge();
        for (int i = 0; i < DEB && (ecount % DEB) != DEB - 1; i++)
            @(negedge clk);
    endtask

    logic [6:0] seg_exp [4];
    logic [3:0] an_exp  [4];
    int         ready_seen;
    bit         found;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 8; i++)
            vt[i] = '{3'(i), 4'h0, 32'h0, 1'b1, 32'h0};
        vt[8]  = '{3'd0, 4'b0001, 32'h0000A5A5, 1'b0, 32'h0};
        vt[9]  = '{3'd0, 4'b0000, 32'h0,        1'b1, 32'h000000A5};
        vt[10] = '{3'd0, 4'b0010, 32'h12345678, 1'b0, 32'h0};
        vt[11] = '{3'd0, 4'b0000, 32'h0,        1'b1, 32'h000056A5};
        vt[12] = '{3'd1, 4'b1111, 32'hFFFFFFFF, 1'b0, 32'h0};
        vt[13] = '{3'd1, 4'b0000, 32'h0,        1'b1, 32'h0};
        vt[14] = '{3'd5, 4'b1111, 32'hFFFFFFFF, 1'b0, 32'h0};
        vt[15] = '{3'd5, 4'b0000, 32'h0,        1'b1, 32'h0};
        vt[16] = '{3'd2, 4'b1111, 32'hABCD1234, 1'b0, 32'h0};
        vt[17] = '{3'd2, 4'b0000, 32'h0,        1'b1, 32'h00001234};
        vt[18] = '{3'd3, 4'b1111, 32'hFFFFFFFC, 1'b0, 32'h0};
        vt[19] = '{3'd3, 4'b0000, 32'h0,        1'b1, 32'h0};
        vt[20] = '{3'd3, 4'b0001, 32'h00000001, 1'b0, 32'h0};
        vt[21] = '{3'd3, 4'b0000, 32'h0,        1'b1, 32'h00000001};
        vt[22] = '{3'd4, 4'b0001, 32'h00000001, 1'b0, 32'h0};
        vt[23] = '{3'd4, 4'b0000, 32'h0,        1'b1, 32'h0};
        seg_exp = '{7'h19, 7'h30, 7'h24, 7'h79};
        an_exp  = '{4'hE, 4'hD, 4'hB, 4'h7};

        repeat (3) @(negedge clk);
        check("rst_ready", {31'd0, iomem_ready}, 32'd0);
        check("rst_rdata", iomem_rdata, 32'd0);
        check("rst_led", {16'd0, led}, 32'd0);
        check("rst_an", {28'd0, an}, 32'hF);
        check("rst_seg", {25'd0, seg}, 32'h7F);
        check("rst_irq", {31'd0, irq}, 32'd0);
        resetn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 24; i++)
            bus(vt[i].off, vt[i].strb, vt[i].wd, vt[i].chk, vt[i].exp,
                $sformatf("vec%0d", i));
        check("led_port", {16'd0, led}, 32'h000056A5);

        // Scanner: CTRL=1, DISP=0x1234; align on the start of digit 0.
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (an != 4'hE) found = 1;
        end
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (an == 4'hE) found = 1;
        end
        check("scan_found", {31'd0, found}, 32'd1);
        for (int s = 0; s < 8; s++) begin
            check($sformatf("scan_an%0d", s), {28'd0, an}, {28'd0, an_exp[s%4]});
            check($sformatf("scan_seg%0d", s), {25'd0, seg}, {25'd0, seg_exp[s%4]});
            repeat (SCAN - 1) @(negedge clk);
            check($sformatf("scan_hold%0d", s), {28'd0, an}, {28'd0, an_exp[s%4]});
            @(negedge clk);
        end
        bus(3'd3, 4'b0001, 32'h0, 1'b0, 32'h0, "ctrl_off");
        check("off_an", {28'd0, an}, 32'hF);
        check("off_seg", {25'd0, seg}, 32'h7F);

        // One-tick glitch on sw[3] must not reach the debounced value.
        sw[3] = 1'b1;
        repeat (DEB) @(negedge clk);
        sw[3] = 1'b0;
        repeat (12) @(negedge clk);
        bus(3'd1, 4'b0000, 32'h0, 1'b1, 32'h0, "glitch_sw");
        bus(3'd4, 4'b0000, 32'h0, 1'b1, 32'h0, "glitch_pend");

        sw[3] = 1'b1;
        repeat (4 * DEB) @(negedge clk);
        bus(3'd1, 4'b0000, 32'h0, 1'b1, 32'h8, "hold_sw");
        bus(3'd4, 4'b0000, 32'h0, 1'b1, 32'h1, "hold_pend");
        check("irq_masked", {31'd0, irq}, 32'd0);
        bus(3'd3, 4'b0001, 32'h3, 1'b0, 32'h0, "ctrl3");
        check("irq_on", {31'd0, irq}, 32'd1);
        bus(3'd4, 4'b0001, 32'h1, 1'b0, 32'h0, "w1c");
        check("irq_off", {31'd0, irq}, 32'd0);
        bus(3'd4, 4'b0000, 32'h0, 1'b1, 32'h0, "w1c_pend");

        // Land the W1C on the exact tick where sw[3] falling is accepted.
        sw[3] = 1'b0;
        repeat (2) @(negedge clk);
        wait_tick_edge();
        @(negedge clk);
        wait_tick_edge();
        bus(3'd4, 4'b0001, 32'h1, 1'b0, 32'h0, "w1c_race");
        bus(3'd4, 4'b0000, 32'h0, 1'b1, 32'h1, "race_pend");
        bus(3'd1, 4'b0000, 32'h0, 1'b1, 32'h0, "race_sw");
        check("race_irq", {31'd0, irq}, 32'd1);

        // Foreign base address: never acknowledged, no write.
        iomem_valid = 1'b1;
        iomem_addr  = 32'h02000000;
        iomem_wstrb = 4'hF;
        iomem_wdata = 32'h0000FFFF;
        ready_seen  = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (iomem_ready) ready_seen++;
        end
        iomem_valid = 1'b0;
        iomem_wstrb = '0;
        check("foreign_ready", 32'(ready_seen), 32'd0);
        bus(3'd0, 4'b0000, 32'h0, 1'b1, 32'h000056A5, "foreign_led");

        // Reset while the acknowledge is high.
        iomem_valid = 1'b1;
        iomem_addr  = 32'h03000000;
        iomem_wstrb = 4'b0011;
        iomem_wdata = 32'h0000FFFF;
        @(posedge clk);
        #1;
        check("ack_high", {31'd0, iomem_ready}, 32'd1);
        resetn = 1'b0;
        #1;
        check("mid_rst_ready", {31'd0, iomem_ready}, 32'd0);
        check("mid_rst_led", {16'd0, led}, 32'd0);
        check("mid_rst_irq", {31'd0, irq}, 32'd0);
        check("mid_rst_an", {28'd0, an}, 32'hF);
        iomem_valid = 1'b0;
        iomem_wstrb = '0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        bus(3'd0, 4'b0000, 32'h0, 1'b1, 32'h0, "post_rst_led");
        bus(3'd4, 4'b0000, 32'h0, 1'b1, 32'h0, "post_rst_pend");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
